// File: rtl/ram_port_arbiter.sv
// Arbiter sharing one 256x16 RAM between the CPU datapath (priority) and the
// program loader, with loader anti-starvation and locked loader bursts.
module ram_port_arbiter #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 8,
   parameter int MAX_WAIT      = 4,
   parameter int BURST_MAX     = 8
) (
   input  logic                     CLK,
   input  logic                     CLR,
   input  logic                     CPU_REQ,
   input  logic                     CPU_WE,
   input  logic [ADDRESS_WIDTH-1:0] CPU_ADDR,
   input  logic [DATA_WIDTH-1:0]    CPU_WDATA,
   output logic                     CPU_GNT,
   output logic                     CPU_RVALID,
   output logic [DATA_WIDTH-1:0]    CPU_RDATA,
   input  logic                     LD_REQ,
   input  logic                     LD_WE,
   input  logic [ADDRESS_WIDTH-1:0] LD_ADDR,
   input  logic [DATA_WIDTH-1:0]    LD_WDATA,
   input  logic                     LD_LOCK,
   output logic                     LD_GNT,
   output logic                     LD_RVALID,
   output logic [DATA_WIDTH-1:0]    LD_RDATA,
   output logic                     RAM_EN,
   output logic                     RAM_WE,
   output logic [ADDRESS_WIDTH-1:0] RAM_ADDR,
   output logic [DATA_WIDTH-1:0]    RAM_WDATA,
   input  logic [DATA_WIDTH-1:0]    RAM_RDATA
);

   typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

   localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
   localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

   state_t     state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic [3:0] burst_cnt_q, burst_cnt_d;
   logic [1:0] rd_owner_q, rd_owner_d;
   logic       cpu_gnt, ld_gnt;

   // A locked loader keeps the RAM; otherwise a starved loader beats the CPU.
   always_comb begin
      cpu_gnt = 1'b0;
      ld_gnt  = 1'b0;
      if (!CLR) begin
         if (state_q == BURST && LD_REQ)               ld_gnt  = 1'b1;
         else if (LD_REQ && wait_cnt_q == MAX_WAIT_C)  ld_gnt  = 1'b1;
         else if (CPU_REQ)                             cpu_gnt = 1'b1;
         else if (LD_REQ)                              ld_gnt  = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      wait_cnt_d  = 4'd0;
      rd_owner_d  = {cpu_gnt & ~CPU_WE, ld_gnt & ~LD_WE};
      case (state_q)
         ARB: begin
            if (ld_gnt && LD_LOCK && BURST_MAX > 1) begin
               state_d     = BURST;
               burst_cnt_d = 4'd1;
            end
         end
         BURST: begin
            if (!LD_LOCK || !ld_gnt || (burst_cnt_q + 4'd1) == BURST_MAX_C) begin
               state_d     = ARB;
               burst_cnt_d = 4'd0;
            end else begin
               burst_cnt_d = burst_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d     = ARB;
            burst_cnt_d = 4'd0;
         end
      endcase
      if (LD_REQ && !ld_gnt)
         wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q     <= ARB;
         wait_cnt_q  <= 4'd0;
         burst_cnt_q <= 4'd0;
         rd_owner_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         rd_owner_q  <= rd_owner_d;
      end
   end

   assign CPU_GNT    = cpu_gnt;
   assign LD_GNT     = ld_gnt;
   assign RAM_EN     = cpu_gnt | ld_gnt;
   assign RAM_WE     = (cpu_gnt & CPU_WE) | (ld_gnt & LD_WE);
   assign RAM_ADDR   = cpu_gnt ? CPU_ADDR  : (ld_gnt ? LD_ADDR  : '0);
   assign RAM_WDATA  = cpu_gnt ? CPU_WDATA : (ld_gnt ? LD_WDATA : '0);

   // Read data is shared; each port only sees it in the cycle its tag is set.
   assign CPU_RVALID = rd_owner_q[1];
   assign LD_RVALID  = rd_owner_q[0];
   assign CPU_RDATA  = {DATA_WIDTH{rd_owner_q[1]}} & RAM_RDATA;
   assign LD_RDATA   = {DATA_WIDTH{rd_owner_q[0]}} & RAM_RDATA;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed per-cycle stimulus with
// hand-derived grant patterns and read-return data checked by a monitor.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        CLR;
   logic        CPU_REQ, CPU_WE, LD_REQ, LD_WE, LD_LOCK;
   logic [7:0]  CPU_ADDR, LD_ADDR, RAM_ADDR;
   logic [15:0] CPU_WDATA, LD_WDATA, RAM_WDATA, RAM_RDATA;
   logic        CPU_GNT, CPU_RVALID, LD_GNT, LD_RVALID, RAM_EN, RAM_WE;
   logic [15:0] CPU_RDATA, LD_RDATA;

   logic [15:0] mem [256];
   logic [15:0] cpu_q[$];
   logic [15:0] ld_q[$];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(8), .MAX_WAIT(4), .BURST_MAX(8)) dut (
      .CLK(clk), .CLR(CLR),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
      .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
      .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
      .LD_LOCK(LD_LOCK), .LD_GNT(LD_GNT), .LD_RVALID(LD_RVALID), .LD_RDATA(LD_RDATA),
      .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
      .RAM_RDATA(RAM_RDATA)
   );

   // Synchronous RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (RAM_EN) begin
         if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
         else        RAM_RDATA     <= mem[RAM_ADDR];
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic set_in(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                         input logic lr, input logic lw, input logic [7:0] la, input logic [15:0] ldd,
                         input logic lk);
      CPU_REQ = cr; CPU_WE = cw; CPU_ADDR = ca; CPU_WDATA = cd;
      LD_REQ = lr; LD_WE = lw; LD_ADDR = la; LD_WDATA = ldd; LD_LOCK = lk;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_gnt(input string nm, input logic exp_cpu, input logic exp_ld);
      #2;
      chk({nm, "_cpu_gnt"}, CPU_GNT, exp_cpu);
      chk({nm, "_ld_gnt"}, LD_GNT, exp_ld);
   endtask

   task automatic idle();
      set_in(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
      next_cycle();
   endtask

   // Monitor: pops the expected read data whenever a port reports RVALID.
   always @(negedge clk) begin
      if (CPU_RVALID === 1'b1) begin
         if (cpu_q.size() == 0) chk("cpu_unexpected_rvalid", 1, 0);
         else chk("cpu_rdata", CPU_RDATA, cpu_q.pop_front());
      end
      if (LD_RVALID === 1'b1) begin
         if (ld_q.size() == 0) chk("ld_unexpected_rvalid", 1, 0);
         else chk("ld_rdata", LD_RDATA, ld_q.pop_front());
      end
      chk("both_rvalid", CPU_RVALID & LD_RVALID, 0);
      chk("both_gnt", CPU_GNT & LD_GNT, 0);
   end

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h10] = 16'h1234;
      mem[8'h11] = 16'h5678;
      mem[8'h20] = 16'hBEEF;
      mem[8'h21] = 16'hCAFE;
      RAM_RDATA = 16'h0;

      // Reset with both requesters active: nothing reaches the RAM.
      CLR = 1'b1;
      set_in(1, 1, 8'h44, 16'h9999, 1, 1, 8'h55, 16'h7777, 1);
      next_cycle();
      for (int c = 0; c < 2; c++) begin
         chk_gnt("reset", 0, 0);
         chk("reset_ram_en", RAM_EN, 0);
         chk("reset_ram_we", RAM_WE, 0);
         chk("reset_ram_addr", RAM_ADDR, 0);
         chk("reset_ram_wdata", RAM_WDATA, 0);
         next_cycle();
      end
      CLR = 1'b0;
      set_in(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 0);
      cpu_q.push_back(16'h1234);
      chk_gnt("post_reset", 1, 0);
      chk("post_reset_addr", RAM_ADDR, 8'h10);
      next_cycle();
      idle();

      // Priority: 4 CPU grants then a forced loader grant, repeating.
      for (int c = 0; c < 10; c++) begin
         logic exp_ld;
         exp_ld = (c == 4 || c == 9);
         set_in(1, 0, 8'h10, 16'h0, 1, 0, 8'h11, 16'h0, 0);
         if (exp_ld) ld_q.push_back(16'h5678);
         else        cpu_q.push_back(16'h1234);
         chk_gnt("prio", !exp_ld, exp_ld);
         next_cycle();
      end
      idle();

      // Burst: forced grant after 4 denials, then 7 locked grants, then CPU.
      for (int c = 0; c < 14; c++) begin
         logic       exp_ld;
         logic [7:0] la;
         exp_ld = (c >= 4 && c < 12);
         la     = (c >= 4) ? 8'(c - 4) : 8'h00;
         set_in(1, 0, 8'h10, 16'h0, (c < 12), 1, la, 16'h00A0 + 16'(la), 1);
         if (!exp_ld) cpu_q.push_back(16'h1234);
         chk_gnt("burst", !exp_ld, exp_ld);
         if (exp_ld) chk("burst_ram_we", RAM_WE, 1);
         next_cycle();
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         set_in(0, 0, 8'h00, 16'h0, 1, 0, 8'(i), 16'h0, 0);
         ld_q.push_back(16'h00A0 + 16'(i));
         chk_gnt("burst_readback", 0, 1);
         next_cycle();
      end
      idle();

      // Lock release: lock drops on the third loader grant, CPU wins next.
      for (int c = 0; c < 8; c++) begin
         logic       exp_ld;
         logic [7:0] la;
         exp_ld = (c >= 4 && c <= 6);
         la     = (c >= 4) ? 8'(8'h30 + c - 4) : 8'h30;
         set_in(1, 0, 8'h10, 16'h0, (c < 7), 1, la, 16'h0055, (c < 6));
         if (!exp_ld) cpu_q.push_back(16'h1234);
         chk_gnt("lock_rel", !exp_ld, exp_ld);
         if (c == 5) chk("lock_rel_burst_cnt1", dut.burst_cnt_q, 1);
         if (c == 6) chk("lock_rel_burst_cnt2", dut.burst_cnt_q, 2);
         if (c == 7) chk("lock_rel_burst_cnt0", dut.burst_cnt_q, 0);
         next_cycle();
      end
      idle();

      // Interleaved reads from alternating owners.
      for (int c = 0; c < 6; c++) begin
         if (c % 2 == 0) begin
            set_in(1, 0, 8'h20, 16'h0, 0, 0, 8'h00, 16'h0, 0);
            cpu_q.push_back(16'hBEEF);
            chk_gnt("interleave", 1, 0);
         end else begin
            set_in(0, 0, 8'h00, 16'h0, 1, 0, 8'h21, 16'h0, 0);
            ld_q.push_back(16'hCAFE);
            chk_gnt("interleave", 0, 1);
         end
         next_cycle();
      end
      idle();

      // Write produces no return; readback sees the written word.
      set_in(1, 1, 8'hFF, 16'h0001, 0, 0, 8'h00, 16'h0, 0);
      chk_gnt("write", 1, 0);
      chk("write_ram_we", RAM_WE, 1);
      chk("write_ram_addr", RAM_ADDR, 8'hFF);
      chk("write_ram_wdata", RAM_WDATA, 16'h0001);
      next_cycle();
      set_in(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
      #2;
      chk("write_no_rvalid", CPU_RVALID, 0);
      chk("idle_ram_en", RAM_EN, 0);
      chk("idle_ram_we", RAM_WE, 0);
      next_cycle();
      set_in(1, 0, 8'hFF, 16'h0, 0, 0, 8'h00, 16'h0, 0);
      cpu_q.push_back(16'h0001);
      chk_gnt("write_readback", 1, 0);
      next_cycle();
      idle();
      idle();
      idle();

      chk("cpu_queue_drained", cpu_q.size(), 0);
      chk("ld_queue_drained", ld_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
